// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship monster spawner: state encoding,
// lane indices and the LFSR feedback polynomial.
package nexys_starship_pkg;

   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_WAIT = 5'b00010,
      ST_PICK = 5'b00100,
      ST_REQ  = 5'b01000,
      ST_OVER = 5'b10000
   } state_t;

   localparam logic [1:0] LANE_TOP    = 2'd0;
   localparam logic [1:0] LANE_BOTTOM = 2'd1;
   localparam logic [1:0] LANE_LEFT   = 2'd2;
   localparam logic [1:0] LANE_RIGHT  = 2'd3;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
      logic [3:0] sel;
      sel = 4'b0000;
      unique case (lane)
         LANE_TOP:    sel = 4'b0001;
         LANE_BOTTOM: sel = 4'b0010;
         LANE_LEFT:   sel = 4'b0100;
         LANE_RIGHT:  sel = 4'b1000;
         default:     sel = 4'b0000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/nexys_starship_lfsr.sv
// Seeded 16-bit Galois LFSR (right shift) that advances only while enabled;
// exposes its low bits as the random lane candidate.
module nexys_starship_lfsr
   import nexys_starship_pkg::*;
#(
   parameter logic [15:0] SEED  = 16'hACE1,
   parameter int unsigned OUT_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic [OUT_W-1:0] o_bits
);

   // An all-zero state never leaves zero, so a zero seed is remapped.
   localparam logic [15:0] START = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] r_lfsr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= START;
      end else if (i_en) begin
         r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign o_bits = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/nexys_starship_spawner.sv
// Monster spawn initiator: tick-driven countdown picks a spawn time, an LFSR
// picks a lane (redirected to a free one), and a request/ack handshake spawns.
module nexys_starship_spawner
   import nexys_starship_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED        = 16'hACE1,
   parameter int unsigned BASE_INTERVAL    = 8,
   parameter int unsigned MIN_INTERVAL     = 2,
   parameter int unsigned SPAWNS_PER_LEVEL = 8,
   parameter int unsigned ACK_TIMEOUT      = 15
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       tick,
   input  logic       play_flag,
   input  logic       gameover,
   input  logic [3:0] monster_sm,
   output logic [3:0] random,
   output logic [1:0] level,
   output logic [7:0] spawn_count,
   output logic       busy
);

   localparam logic [8:0] BASE_W   = 9'(BASE_INTERVAL);
   localparam logic [8:0] MIN_W    = 9'(MIN_INTERVAL);
   localparam logic [7:0] LVL_LAST = 8'(SPAWNS_PER_LEVEL - 1);
   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

   // Interval shrinks by two ticks per level, clamped so it never underflows
   // below the floor.
   function automatic logic [7:0] interval_for(input logic [1:0] lvl);
      logic [8:0] dec;
      dec = {6'd0, lvl, 1'b0};
      if (BASE_W >= dec + MIN_W) begin
         return 8'(BASE_W - dec);
      end
      return 8'(MIN_W);
   endfunction

   state_t      r_state;
   logic [7:0]  r_cd;
   logic [3:0]  r_random;
   logic [1:0]  r_lane;
   logic [7:0]  r_ack_cnt;
   logic [1:0]  r_level;
   logic [7:0]  r_lvl_cnt;
   logic [7:0]  r_count;
   logic        r_busy;

   state_t      w_state_nxt;
   logic [7:0]  w_cd_nxt;
   logic [3:0]  w_random_nxt;
   logic [1:0]  w_lane_nxt;
   logic [7:0]  w_ack_cnt_nxt;
   logic [1:0]  w_level_nxt;
   logic [7:0]  w_lvl_cnt_nxt;
   logic [7:0]  w_count_nxt;

   logic [1:0]  w_cand;
   logic [1:0]  w_pick;
   logic        w_found;
   logic        w_lfsr_en;

   assign w_lfsr_en = (r_state != ST_IDLE);

   nexys_starship_lfsr #(
      .SEED  (LFSR_SEED),
      .OUT_W (2)
   ) u_lfsr (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_en    (w_lfsr_en),
      .o_bits  (w_cand)
   );

   // Walk candidate+3 down to candidate+0 so the nearest free lane wins.
   always_comb begin
      logic [1:0] v_lane;
      w_found = 1'b0;
      w_pick  = w_cand;
      for (int k = 3; k >= 0; k--) begin
         v_lane = w_cand + 2'(k);
         if (!monster_sm[v_lane]) begin
            w_found = 1'b1;
            w_pick  = v_lane;
         end
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the case below can leave one unassigned and infer a latch.
      w_state_nxt   = r_state;
      w_cd_nxt      = r_cd;
      w_random_nxt  = r_random;
      w_lane_nxt    = r_lane;
      w_ack_cnt_nxt = r_ack_cnt;
      w_level_nxt   = r_level;
      w_lvl_cnt_nxt = r_lvl_cnt;
      w_count_nxt   = r_count;

      if (r_state != ST_IDLE && gameover) begin
         w_state_nxt  = ST_OVER;
         w_random_nxt = 4'b0000;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_random_nxt = 4'b0000;
               if (play_flag) begin
                  w_state_nxt   = ST_WAIT;
                  w_cd_nxt      = interval_for(2'd0);
                  w_level_nxt   = 2'd0;
                  w_lvl_cnt_nxt = 8'd0;
                  w_count_nxt   = 8'd0;
               end
            end
            ST_WAIT: begin
               if (tick) begin
                  if (r_cd == 8'd1) w_state_nxt = ST_PICK;
                  else              w_cd_nxt    = r_cd - 8'd1;
               end
            end
            ST_PICK: begin
               if (w_found) begin
                  w_state_nxt   = ST_REQ;
                  w_random_nxt  = lane_onehot(w_pick);
                  w_lane_nxt    = w_pick;
                  w_ack_cnt_nxt = 8'd0;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_cd_nxt    = interval_for(r_level);
               end
            end
            ST_REQ: begin
               if (monster_sm[r_lane]) begin
                  w_random_nxt = 4'b0000;
                  w_count_nxt  = r_count + 8'd1;
                  if (r_lvl_cnt == LVL_LAST) begin
                     w_lvl_cnt_nxt = 8'd0;
                     if (r_level != 2'd3) w_level_nxt = r_level + 2'd1;
                  end else begin
                     w_lvl_cnt_nxt = r_lvl_cnt + 8'd1;
                  end
                  // Reload sees the level as updated on this same edge.
                  w_cd_nxt    = interval_for(w_level_nxt);
                  w_state_nxt = ST_WAIT;
               end else if (r_ack_cnt == ACK_LAST) begin
                  w_random_nxt = 4'b0000;
                  w_cd_nxt     = interval_for(r_level);
                  w_state_nxt  = ST_WAIT;
               end else begin
                  w_ack_cnt_nxt = r_ack_cnt + 8'd1;
               end
            end
            ST_OVER: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_random_nxt = 4'b0000;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state   <= ST_IDLE;
         r_cd      <= 8'd0;
         r_random  <= 4'b0000;
         r_lane    <= LANE_TOP;
         r_ack_cnt <= 8'd0;
         r_level   <= 2'd0;
         r_lvl_cnt <= 8'd0;
         r_count   <= 8'd0;
         r_busy    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_state   <= w_state_nxt;
         r_cd      <= w_cd_nxt;
         r_random  <= w_random_nxt;
         r_lane    <= w_lane_nxt;
         r_ack_cnt <= w_ack_cnt_nxt;
         r_level   <= w_level_nxt;
         r_lvl_cnt <= w_lvl_cnt_nxt;
         r_count   <= w_count_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
      end
   end

   assign random      = r_random;
   assign level       = r_level;
   assign spawn_count = r_count;
   assign busy        = r_busy;

endmodule

// File: doc/nexys_starship_spawner.md
# nexys_starship_spawner

Monster spawn initiator for Nexys Starship. Drives the one-bit spawn request (`*_random`) into each of the four lane monster state machines (top, bottom, left, right) and reads back their occupancy (`*_monster_sm`) as acknowledge. Spawn times come from a tick-driven countdown whose period shrinks as the game level rises. The target lane comes from an LFSR, redirected to a free lane when the chosen one is occupied.

## Interface
Parameters:
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Zero is replaced by 16'h0001.
- `BASE_INTERVAL`, 8: ticks between spawns at level 0 (range 2..255).
- `MIN_INTERVAL`, 2: floor on the spawn interval (at least 1).
- `SPAWNS_PER_LEVEL`, 8: successful spawns per level increment.
- `ACK_TIMEOUT`, 15: maximum Clk cycles a request is held without acknowledge.

Ports:
- `Clk` in 1: system clock. This is the block's only clock.
- `Reset` in 1: asynchronous, active-low reset.
- `tick` in 1: one-Clk-wide game-time pulse, already synchronous to `Clk`.
- `play_flag` in 1: game start request.
- `gameover` in 1: OR of all lane gameover flags.
- `monster_sm` in 4: lane occupancy, bit order {right, left, bottom, top}.
- `random` out 4: spawn requests, same bit order. At most one bit is high at a time.
- `level` out 2: current difficulty level, saturates at 3.
- `spawn_count` out 8: successful spawns since game start; wraps at 255 to 0.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, PICK, REQ, OVER.
- Reset (`Reset`=0): state IDLE; `random`=0, `level`=0, `spawn_count`=0, `busy`=0; LFSR=seed; countdown=0.
- IDLE
  - Outputs are cleared.
  - `play_flag`=1 moves to WAIT, with countdown loaded to the level-0 interval, `level`=0 and `spawn_count`=0.
- WAIT
  - On each `tick`, countdown decrements.
  - A `tick` arriving while countdown=1 moves to PICK on the next cycle.
  - Non-tick cycles hold the countdown.
- PICK (one cycle)
  - Candidate lane = LFSR[1:0].
  - If the candidate is occupied, search candidate+1, +2, +3 (mod 4) and take the first free lane.
  - A free lane moves to REQ with `random[lane]`=1.
  - If all four lanes are occupied, issue no request, reload the countdown and return to WAIT.
- REQ (handshake)
  - `random[lane]` is held high until `monster_sm[lane]`=1 is sampled.
  - On acknowledge: drop `random` the same edge, increment `spawn_count`, reload the countdown, go to WAIT.
  - After `ACK_TIMEOUT` cycles without acknowledge: drop `random`, do not count, reload, go to WAIT.
- Level
  - `level` increments (saturating at 3) on each acknowledge that makes the successful count within the level reach `SPAWNS_PER_LEVEL`; the within-level counter then clears.
  - interval = max(`BASE_INTERVAL` − 2·`level`, `MIN_INTERVAL`), computed in 9-bit unsigned with no underflow.
  - Each reload uses the level value after any increment on that edge.
- LFSR
  - 16-bit Galois, taps 16'hB400, shifts right.
  - Advances every Clk in every state except IDLE.
- Gameover
  - `gameover`=1 in any non-IDLE state moves to OVER on the next edge and clears `random`.
  - Gameover has priority over acknowledge and tick.
  - OVER holds `level` and `spawn_count` for display and returns to IDLE when `gameover`=0.
- `play_flag` is ignored outside IDLE.

## Timing
- Request latency: `random` rises 2 Clk after the terminal tick edge (WAIT→PICK, then PICK→REQ).
- A lane SM acknowledges no earlier than 1 Clk after seeing the request, so `random` is high for at least 1 cycle.
- Acknowledge and drop are on the same edge; `random` is low the cycle after `monster_sm[lane]` is sampled high.
- A `tick` arriving in PICK or REQ is discarded. The countdown restarts only on reload.
- A reset assertion mid-REQ drops `random` asynchronously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `nexys_starship_pkg` holds:
  - state encodings (one-hot, 5 bits);
  - lane index constants TOP=0, BOTTOM=1, LEFT=2, RIGHT=3;
  - the LFSR tap constant.
- One sub-module, `nexys_starship_lfsr`: seeded Galois LFSR with enable.
- The free-lane search and the interval arithmetic stay inline.

## Test plan
- Reset, then `play_flag` pulse, all lanes free, `tick` every 4 Clk, acknowledge 1 Clk after request → first `random` one-hot rises 2 Clk after the 8th tick; `spawn_count`=1.
- LFSR[1:0]=0 with `monster_sm`=4'b0011 → request on lane 2 (`random`=4'b0100). With `monster_sm`=4'b1111 → no request, state returns to WAIT.
- No acknowledge → `random` high exactly 15 Clk, then low; `spawn_count` unchanged.
- 24 acknowledged spawns → `level` steps 1, 2, 3 at counts 8, 16, 24; intervals 6, 4, 2. A 25th spawn keeps `level`=3 and interval 2.
- `gameover` asserted in the same cycle as an acknowledge in REQ → OVER, `random`=0, `spawn_count` not incremented. Deassert → IDLE; the next `play_flag` clears the counters.
- `Reset` driven low mid-REQ, asynchronous to Clk → `random`=0, `level`=0 and `busy`=0 immediately, without waiting for a Clk edge.
